// File: rtl/gs_div_pkg.sv
// Shared types and constants for the Goldschmidt divider: FSM states,
// internal-width helpers, the 1.0 constant and saturation values.
package gs_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_MUL,
    S_UPD,
    S_FIN
  } gs_state_e;

  localparam int unsigned GS_MAXW  = 64;
  localparam int unsigned GS_MAXIW = 3 * GS_MAXW;

  function automatic int unsigned gs_iw(input int unsigned wid);
    return 3 * wid;
  endfunction

  function automatic int unsigned gs_if(input int unsigned wid);
    return 2 * wid;
  endfunction

  function automatic logic [GS_MAXIW-1:0] gs_one(input int unsigned if_bits);
    return GS_MAXIW'(1) << if_bits;
  endfunction

  function automatic logic [GS_MAXW-1:0] gs_umax(input int unsigned wid);
    return (GS_MAXW'(1) << wid) - GS_MAXW'(1);
  endfunction

  function automatic logic [GS_MAXW-1:0] gs_smax(input int unsigned wid);
    return (GS_MAXW'(1) << (wid - 1)) - GS_MAXW'(1);
  endfunction

  function automatic logic [GS_MAXW-1:0] gs_smin(input int unsigned wid);
    return GS_MAXW'(1) << (wid - 1);
  endfunction

endpackage

// File: rtl/gs_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module gs_lzc #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  // Upward scan: the highest set bit is the last one to overwrite cnt_o.
  always_comb begin
    cnt_o = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/goldschmidt_div_unit.sv
// Multi-cycle Goldschmidt fixed-point divider, Q(WID-FRAC).FRAC operands.
// Define GOLDSCHMIDT_ROUND_EN to round the final quotient to nearest (ties away).
module goldschmidt_div_unit
  import gs_div_pkg::*;
#(
  parameter int unsigned WID     = 32,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned ITER    = 5,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           sgn,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic [WID-1:0] q,
  output logic           done,
  output logic           busy,
  output logic           dvbyzr,
  output logic           ovf
);

  localparam int unsigned IW  = gs_iw(WID);
  localparam int unsigned IF  = gs_if(WID);
  localparam int unsigned PW  = 2 * IW;
  localparam int unsigned MW  = IW - IF + FRAC + 1;
  localparam int unsigned LZW = $clog2(WID + 1);
  localparam int unsigned ICW = $clog2(ITER + 1);
  localparam int unsigned MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [IW-1:0]  ONE    = IW'(gs_one(IF));
  localparam logic [IW-1:0]  TWO    = ONE << 1;
  localparam logic [PW-1:0]  HALF_P = PW'(1) << (IF - 1);
  localparam logic [WID-1:0] UMAX   = WID'(gs_umax(WID));
  localparam logic [WID-1:0] SMAX   = WID'(gs_smax(WID));
  localparam logic [WID-1:0] SMIN   = WID'(gs_smin(WID));

  gs_state_e        state_q;
  logic [IW-1:0]    n_q, d_q, f_q;
  logic [ICW-1:0]   it_q;
  logic [MCW-1:0]   lat_q;
  logic             sgn_q, neg_q;
  logic [WID-1:0]   q_q;
  logic             done_q, busy_q, dvbyzr_q, ovf_q;

  logic [WID-1:0]   a_mag, b_mag;
  logic [LZW-1:0]   lz;
  logic [IW-1:0]    n_sh, d_sh;
  logic [PW-1:0]    prod_n, prod_d;
  logic [IW-1:0]    n_d, d_d;
  logic [MW-1:0]    mag, lim;
  logic [WID-1:0]   mag_lo, sat, q_fin;
  logic             ovf_fin;

  gs_lzc #(.W(WID), .CW(LZW)) u_lzc (
    .in_i  (d_q[WID-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    a_mag  = (sgn && a[WID-1]) ? -a : a;
    b_mag  = (sgn && b[WID-1]) ? -b : b;
    // Normalised values carry WID fraction bits below the integer shift, so D lands in [0.5,1).
    n_sh   = (n_q << lz) << WID;
    d_sh   = (d_q << lz) << WID;
    prod_n = PW'(n_q) * PW'(f_q);
    prod_d = PW'(d_q) * PW'(f_q);
    n_d    = IW'((prod_n + HALF_P) >> IF);
    d_d    = IW'((prod_d + HALF_P) >> IF);
`ifdef GOLDSCHMIDT_ROUND_EN
    mag    = MW'(({1'b0, n_q} + ((IW + 1)'(1) << (IF - FRAC - 1))) >> (IF - FRAC));
`else
    mag    = MW'(n_q >> (IF - FRAC));
`endif
    mag_lo = mag[WID-1:0];
    sat    = !sgn_q ? UMAX : (neg_q ? SMIN : SMAX);
    lim    = !sgn_q ? MW'(UMAX) : (neg_q ? MW'(SMIN) : MW'(SMAX));
    ovf_fin = (mag > lim);
    q_fin  = ovf_fin ? sat : (neg_q ? -mag_lo : mag_lo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      d_q      <= '0;
      f_q      <= '0;
      it_q     <= '0;
      lat_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      q_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dvbyzr_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ld) begin
            busy_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dvbyzr_q <= (b == '0);
            sgn_q    <= sgn;
            neg_q    <= sgn & (a[WID-1] ^ b[WID-1]);
            n_q      <= IW'(a_mag);
            d_q      <= IW'(b_mag);
            state_q  <= (b == '0) ? S_FIN : S_NORM;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_NORM: begin
          n_q     <= n_sh;
          d_q     <= d_sh;
          f_q     <= TWO - d_sh;
          it_q    <= '0;
          lat_q   <= '0;
          state_q <= S_MUL;
        end
        S_MUL: begin
          if (lat_q == MCW'(MUL_LAT - 1)) begin
            lat_q   <= '0;
            state_q <= S_UPD;
          end else begin
            lat_q <= lat_q + MCW'(1);
          end
        end
        S_UPD: begin
          n_q     <= n_d;
          d_q     <= d_d;
          f_q     <= TWO - d_d;
          it_q    <= it_q + ICW'(1);
          state_q <= (d_d == ONE || it_q == ICW'(ITER - 1)) ? S_FIN : S_MUL;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
          if (dvbyzr_q) begin
            q_q <= sat;
          end else begin
            q_q   <= q_fin;
            ovf_q <= ovf_fin;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign q      = q_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign dvbyzr = dvbyzr_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_goldschmidt_div_unit.sv
// Self-checking bench for goldschmidt_div_unit: directed cases plus random
// operands checked against an exact-rational quotient model.
module tb_goldschmidt_div_unit;

`ifdef GOLDSCHMIDT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ld, sgn;
  logic [31:0] a, b, q;
  logic        done, busy, dvbyzr, ovf;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  goldschmidt_div_unit #(.WID(32), .FRAC(16), .ITER(5), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .ld(ld), .sgn(sgn), .a(a), .b(b),
    .q(q), .done(done), .busy(busy), .dvbyzr(dvbyzr), .ovf(ovf)
  );

  // Exact quotient from the real ratio; drop=1 gives the result one LSB lower in magnitude.
  function automatic void model_div(input logic [31:0] av, input logic [31:0] bv, input bit s,
                                    input bit drop, output logic [31:0] qe, output bit ove,
                                    output bit dze);
    longint unsigned ma, mb, num, quo, rem, lim;
    bit neg;
    dze = (bv == 32'd0);
    ove = 1'b0;
    if (dze) begin
      qe = !s ? 32'hFFFF_FFFF : (av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      return;
    end
    ma  = (s && av[31]) ? (64'h1_0000_0000 - 64'(av)) : 64'(av);
    mb  = (s && bv[31]) ? (64'h1_0000_0000 - 64'(bv)) : 64'(bv);
    neg = s && (av[31] != bv[31]);
    num = ma << 16;
    quo = num / mb;
    rem = num % mb;
    if (RND && (2 * rem >= mb)) quo++;
    if (drop && quo != 0) quo--;
    lim = !s ? 64'hFFFF_FFFF : (neg ? 64'h8000_0000 : 64'h7FFF_FFFF);
    if (quo > lim) begin
      ove = 1'b1;
      qe  = !s ? 32'hFFFF_FFFF : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else begin
      qe = 32'(quo);
      if (neg) qe = -qe;
    end
  endfunction

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit s);
    a = av; b = bv; sgn = s; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge; returns in the done cycle.
  task automatic wait_done(output int lat, output bit bz_ok);
    lat   = -1;
    bz_ok = 1'b1;
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (busy !== 1'b1) bz_ok = 1'b0;
      if (done === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks += 5;
    if (q !== 32'd0)     begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (dvbyzr !== 1'b0) begin failures++; $display("FAIL reset_dvbyzr got=%b exp=0", dvbyzr); end
    if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_unsigned_basic();
    int lat; bit bz;
    issue(32'h0006_0000, 32'h0002_0000, 1'b0);
    wait_done(lat, bz);
    checks += 5;
    if (lat != 17) begin failures++; $display("FAIL u6d2_latency got=%0d exp=17", lat); end
    if (!(q === 32'h0003_0000 || (!RND && q === 32'h0002_FFFF)))
      begin failures++; $display("FAIL u6d2_q got=%h exp=00030000", q); end
    if (ovf !== 1'b0)    begin failures++; $display("FAIL u6d2_ovf got=%b exp=0", ovf); end
    if (dvbyzr !== 1'b0) begin failures++; $display("FAIL u6d2_dvbyzr got=%b exp=0", dvbyzr); end
    if (!bz)             begin failures++; $display("FAIL u6d2_busy got=0 exp=1"); end
    @(posedge clk); #1;
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", busy); end
  endtask

  task automatic test_signed_basic();
    int lat; bit bz;
    issue(32'hFFFD_0000, 32'h0002_0000, 1'b1);
    wait_done(lat, bz);
    checks += 3;
    if (lat != 17) begin failures++; $display("FAIL s3d2_latency got=%0d exp=17", lat); end
    if (!(q === 32'hFFFE_8000 || (!RND && q === 32'hFFFE_8001)))
      begin failures++; $display("FAIL s3d2_q got=%h exp=fffe8000", q); end
    if (!bz) begin failures++; $display("FAIL s3d2_busy got=0 exp=1"); end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] av [3] = '{32'h0001_0000, 32'h8000_0000, 32'h0000_1234};
    bit          sv [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] qv [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int lat; bit bz;
    for (int i = 0; i < 3; i++) begin
      issue(av[i], 32'd0, sv[i]);
      wait_done(lat, bz);
      checks += 3;
      if (lat != 1)        begin failures++; $display("FAIL dz%0d_latency got=%0d exp=1", i, lat); end
      if (dvbyzr !== 1'b1) begin failures++; $display("FAIL dz%0d_flag got=%b exp=1", i, dvbyzr); end
      if (q !== qv[i])     begin failures++; $display("FAIL dz%0d_q got=%h exp=%h", i, q, qv[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] av [3] = '{32'hFFFF_0000, 32'h7FFF_0000, 32'h8000_0000};
    bit          sv [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] qv [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    int lat; bit bz;
    for (int i = 0; i < 3; i++) begin
      issue(av[i], 32'h0000_0001, sv[i]);
      wait_done(lat, bz);
      checks += 4;
      if (lat != 17)       begin failures++; $display("FAIL ovf%0d_latency got=%0d exp=17", i, lat); end
      if (ovf !== 1'b1)    begin failures++; $display("FAIL ovf%0d_flag got=%b exp=1", i, ovf); end
      if (dvbyzr !== 1'b0) begin failures++; $display("FAIL ovf%0d_dvbyzr got=%b exp=0", i, dvbyzr); end
      if (q !== qv[i])     begin failures++; $display("FAIL ovf%0d_q got=%h exp=%h", i, q, qv[i]); end
    end
  endtask

  task automatic test_early_term();
    int lat; bit bz;
    // D starts at 1-2^-32; the second update rounds to exactly 1.0, so k=2.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bz);
    checks += 3;
    if (lat != 8)           begin failures++; $display("FAIL early_latency got=%0d exp=8", lat); end
    if (q !== 32'h0001_0000) begin failures++; $display("FAIL early_q got=%h exp=00010000", q); end
    if (ovf !== 1'b0)       begin failures++; $display("FAIL early_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid_op();
    int lat; bit bz; bit seen;
    issue(32'h0006_0000, 32'h0002_0000, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks += 3;
    if (seen)          begin failures++; $display("FAIL rst_mid_done got=1 exp=0"); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (q !== 32'd0)   begin failures++; $display("FAIL rst_mid_q got=%h exp=0", q); end
    issue(32'h0001_0000, 32'h0003_0000, 1'b0);
    wait_done(lat, bz);
    checks += 2;
    if (lat != 17) begin failures++; $display("FAIL third_latency got=%0d exp=17", lat); end
    if (!(q === 32'h0000_5555 || (!RND && q === 32'h0000_5554)))
      begin failures++; $display("FAIL third_q got=%h exp=00005555", q); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2; bit bz, bz2;
    issue(32'h0006_0000, 32'h0002_0000, 1'b0);
    a = 32'h1234_5678; b = 32'h0000_0003; sgn = 1'b1; ld = 1'b1;
    wait_done(lat, bz);
    checks += 2;
    if (lat != 17) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=17", lat); end
    if (!(q === 32'h0003_0000 || (!RND && q === 32'h0002_FFFF)))
      begin failures++; $display("FAIL b2b_first_q got=%h exp=00030000", q); end
    a = 32'h0001_0000; b = 32'h0003_0000; sgn = 1'b0;
    @(posedge clk); #1 ld = 1'b0;
    wait_done(lat2, bz2);
    checks += 3;
    if (lat2 != 17) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=17", lat2); end
    if (!bz2)       begin failures++; $display("FAIL b2b_busy got=0 exp=1"); end
    if (!(q === 32'h0000_5555 || (!RND && q === 32'h0000_5554)))
      begin failures++; $display("FAIL b2b_second_q got=%h exp=00005555", q); end
  endtask

  task automatic test_random();
    logic [31:0] av, bv, q0, q1;
    bit s, ov0, ov1, dz0, dz1, ok, lat_ok;
    int lat; bit bz;
    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      av = $urandom >> $urandom_range(0, 16);
      bv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) bv = 32'd0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(av, bv, s);
      wait_done(lat, bz);
      model_div(av, bv, s, 1'b0, q0, ov0, dz0);
      model_div(av, bv, s, 1'b1, q1, ov1, dz1);
      ok     = (q === q0 && ovf === ov0) || (!dz0 && q === q1 && ovf === ov1);
      lat_ok = dz0 ? (lat == 1) : (lat >= 5 && lat <= 17 && (lat - 2) % 3 == 0);
      checks += 4;
      if (!ok) begin
        failures++;
        $display("FAIL rand%0d_q a=%h b=%h sgn=%b got=%h/%b exp=%h/%b", i, av, bv, s, q, ovf, q0, ov0);
      end
      if (dvbyzr !== dz0) begin failures++; $display("FAIL rand%0d_dvbyzr got=%b exp=%b", i, dvbyzr, dz0); end
      if (!lat_ok) begin failures++; $display("FAIL rand%0d_latency got=%0d", i, lat); end
      if (!bz)     begin failures++; $display("FAIL rand%0d_busy got=0 exp=1", i); end
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; sgn = 1'b0; a = '0; b = '0;
    test_reset();
    test_unsigned_basic();
    test_signed_basic();
    test_div_by_zero();
    test_overflow();
    test_early_term();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
